// File: rtl/height_conv_seq.sv
// height_conv_seq
//   Sequential total-inches to feet/inches converter. A restoring divide-by-12
//   produces one quotient bit per cycle, MSB first. Quotients above MAX_FEET
//   clamp to MAX_FEET ft 11 in. A single result is held until the consumer
//   takes it.
//
//   Optional build macro: HEIGHT_CONV_SAT_FLAG_EN adds the registered 'sat'
//   output, which flags a clamped result.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_total carries a measurement
//   in_ready   out  block can accept a measurement (IDLE only)
//   in_total   in   [IN_W-1:0] total inches, unsigned
//   out_valid  out  feet/inches hold a result (DONE only)
//   out_ready  in   consumer takes the result
//   feet       out  [FEET_W-1:0] feet, saturated at MAX_FEET
//   inches     out  [3:0] inches, 0..11
//   sat        out  result was clamped (HEIGHT_CONV_SAT_FLAG_EN only)
//
// state | meaning
// IDLE  | waiting for a measurement, in_ready high
// DIV   | shifting out one quotient bit per cycle
// DONE  | result held, out_valid high until out_ready
module height_conv_seq #(
    parameter int IN_W     = 10,
    parameter int FEET_W   = 4,
    parameter int MAX_FEET = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_total,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FEET_W-1:0] feet,
    output logic [3:0]        inches
`ifdef HEIGHT_CONV_SAT_FLAG_EN
    ,
    output logic              sat
`endif
);

    localparam int CNT_W = $clog2(IN_W);
    localparam logic [IN_W-1:0]   MAX_Q    = IN_W'(MAX_FEET);
    localparam logic [FEET_W-1:0] MAX_FT   = FEET_W'(MAX_FEET);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [IN_W-1:0]  dividend;
    logic [IN_W-1:0]  quo;
    logic [4:0]       rem;
    logic [CNT_W-1:0] cnt;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract 12 whenever it fits.
    logic [4:0]      rem_sh;
    logic            qbit;
    logic [4:0]      rem_nx;
    logic [IN_W-1:0] quo_nx;
    logic            last_step;
    logic            clamp;

    assign rem_sh    = {rem[3:0], dividend[IN_W-1]};
    assign qbit      = (rem_sh >= 5'd12);
    assign rem_nx    = qbit ? (rem_sh - 5'd12) : rem_sh;
    assign quo_nx    = {quo[IN_W-2:0], qbit};
    assign last_step = (state == DIV) && (cnt == '0);
    assign clamp     = (quo_nx > MAX_Q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid)       state_nx = DIV;
            DIV:  if (cnt == '0)      state_nx = DONE;
            DONE: if (out_ready)      state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
        end else if (state == IDLE && in_valid) begin
            dividend <= in_total;
            quo      <= '0;
            rem      <= '0;
            cnt      <= CNT_LOAD;
        end else if (state == DIV) begin
            dividend <= {dividend[IN_W-2:0], 1'b0};
            quo      <= quo_nx;
            rem      <= rem_nx;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Result registers load only on the final divide step and otherwise keep
    // their value, including after the handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feet   <= '0;
            inches <= '0;
        end else if (last_step) begin
            if (clamp) begin
                feet   <= MAX_FT;
                inches <= 4'd11;
            end else begin
                feet   <= quo_nx[FEET_W-1:0];
                inches <= rem_nx[3:0];
            end
        end
    end

`ifdef HEIGHT_CONV_SAT_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (last_step) begin
            sat <= clamp;
        end
    end
`endif

endmodule

// File: tb/tb_height_conv_seq.sv
module tb_height_conv_seq;

    localparam int IN_W     = 10;
    localparam int FEET_W   = 4;
    localparam int MAX_FEET = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_total;
    logic              out_valid;
    logic              out_ready;
    logic [FEET_W-1:0] feet;
    logic [3:0]        inches;
`ifdef HEIGHT_CONV_SAT_FLAG_EN
    logic              sat;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    height_conv_seq #(
        .IN_W     (IN_W),
        .FEET_W   (FEET_W),
        .MAX_FEET (MAX_FEET)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_total  (in_total),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .feet      (feet),
        .inches    (inches)
`ifdef HEIGHT_CONV_SAT_FLAG_EN
        ,
        .sat       (sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer division with clamping.
    task automatic model(input int total, output int m_feet, output int m_in, output int m_sat);
        int q;
        q = total / 12;
        if (q > MAX_FEET) begin
            m_feet = MAX_FEET;
            m_in   = 11;
            m_sat  = 1;
        end else begin
            m_feet = q;
            m_in   = total % 12;
            m_sat  = 0;
        end
    endtask

    task automatic check_result(input string tag, input int total);
        int mf, mi, ms;
        model(total, mf, mi, ms);
        check({tag, "_feet"}, int'(feet), mf);
        check({tag, "_inches"}, int'(inches), mi);
`ifdef HEIGHT_CONV_SAT_FLAG_EN
        check({tag, "_sat"}, int'(sat), ms);
`endif
    endtask

    // One full conversion: accept, count edges to out_valid, hold for 'hold'
    // cycles with out_ready low, then hand off. 'inject' pulses in_valid=99
    // during DIV.
    task automatic convert(input int total, input int hold, input bit inject, input string tag);
        int k;
        int mf, mi, ms;
        model(total, mf, mi, ms);
        @(negedge clk);
        check({tag, "_rdy_idle"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_total = IN_W'(total);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            if (inject && k == 2) begin
                in_valid = 1'b1;
                in_total = IN_W'(99);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, k, IN_W);
        check({tag, "_rdy_done"}, int'(in_ready), 0);
        check_result(tag, total);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check({tag, "_hold_rdy"}, int'(in_ready), 0);
            check({tag, "_hold_feet"}, int'(feet), mf);
            check({tag, "_hold_inches"}, int'(inches), mi);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, int'(out_valid), 0);
        check({tag, "_post_rdy"}, int'(in_ready), 1);
        check({tag, "_post_feet"}, int'(feet), mf);
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_total  = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_feet", int'(feet), 0);
        check("rst_inches", int'(inches), 0);
`ifdef HEIGHT_CONV_SAT_FLAG_EN
        check("rst_sat", int'(sat), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        convert(70, 0, 1'b0, "nom70");
        convert(0, 0, 1'b0, "zero");
        convert(107, 0, 1'b0, "b107");
        convert(12, 0, 1'b0, "b12");
        convert(108, 0, 1'b0, "sat108");
        convert(1023, 0, 1'b0, "sat1023");
        convert(70, 20, 1'b0, "bp70");
        convert(70, 0, 1'b1, "ign99");

        // Reset in the middle of DIV: previous result (5/10) must vanish.
        @(negedge clk);
        in_valid = 1'b1;
        in_total = IN_W'(70);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (k < 4) begin
            @(posedge clk);
            #1;
            k++;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_rdy", int'(in_ready), 1);
        check("midrst_feet", int'(feet), 0);
        check("midrst_inches", int'(inches), 0);
`ifdef HEIGHT_CONV_SAT_FLAG_EN
        check("midrst_sat", int'(sat), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        convert(36, 0, 1'b0, "after36");

        for (int i = 0; i < 30; i++) begin
            convert(int'($urandom_range(0, (1 << IN_W) - 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/height_conv_seq.md
# height_conv_seq

Sequential, parametrised height-unit converter: accepts a total-inches measurement of configurable width and produces feet and inches. It uses a multi-cycle restoring divide-by-12, with valid/ready handshakes on both sides and saturation to a configurable maximum display height. It sits between the distance-to-height stage and the display encoder, and decouples them with a one-result output buffer.

## Interface
Parameters:
- IN_W, default 10 — width of the input total-inches value; legal range 4..16.
- FEET_W, default 4 — width of the feet output.
- MAX_FEET, default 8 — largest displayable feet value; must be ≤ 2^FEET_W − 1.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  — single clock; all state changes on the rising edge.
- rst_n  input  1  — asynchronous, active-low reset.
- in_valid  input  1  — in_total carries a measurement.
- in_ready  output  1  — the block can accept a measurement.
- in_total  input  IN_W  — total height in inches, unsigned.
- out_valid  output  1  — feet and inches hold a result.
- out_ready  input  1  — the consumer takes the result.
- feet  output  FEET_W  — feet portion, saturated.
- inches  output  4  — inches portion, 0..11.
- sat  output  1  — result was clamped. Present only with HEIGHT_CONV_SAT_FLAG_EN.

## Operation
- FSM states: IDLE, DIV, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_total into the dividend shift register, clear the remainder (5 bits) and quotient (IN_W bits), load bit counter = IN_W − 1, go to DIV.
- DIV: one quotient bit per cycle, MSB first.
  - rem' = {rem[3:0], dividend MSB}.
  - If rem' ≥ 12: subtract 12 and shift in quotient bit 1; else shift in 0.
  - in_ready = 0. in_valid is ignored and not captured.
  - When the counter reaches 0, register the results and go to DONE.
- Result formation, on the last DIV edge:
  - If quotient > MAX_FEET: feet = MAX_FEET, inches = 11, sat = 1.
  - Else: feet = quotient[FEET_W−1:0], inches = remainder[3:0], sat = 0.
  - The remainder is always ≤ 11, so no inches clamp is needed.
- DONE:
  - out_valid = 1.
  - feet, inches and sat stay stable until out_valid & out_ready.
  - On out_valid & out_ready, go to IDLE.
  - in_ready = 0 in DONE. No new capture happens in the handoff cycle.
- Output registers keep their last value after handoff. Only out_valid drops.
- Arithmetic is unsigned throughout. No rounding. in_total = 0 is legal.

## Timing
- Reset values (asynchronous, on rst_n = 0):
  - State = IDLE, in_ready = 1, out_valid = 0.
  - feet = 0, inches = 0, sat = 0.
  - Counter, remainder, quotient and dividend = 0.
- Latency: the accepting edge is edge 0. The DIV edges are edges 1..IN_W. out_valid is high immediately after edge IN_W.
- Throughput with out_ready held high: one result per IN_W + 2 cycles. in_ready returns high the cycle after the handoff edge.
- Back-pressure: holding out_ready low keeps the block in DONE indefinitely with outputs frozen. No input is lost, because in_ready stays 0.
- Reset mid-operation (DIV or DONE): abort immediately and return to the reset values. The partial result is discarded and no out_valid pulse is produced.
- The in_valid / out_ready handshakes are independent. No combinational path from out_ready to in_ready.

## Configuration
- HEIGHT_CONV_SAT_FLAG_EN defined: the sat output port exists and is registered as described.
- Not defined: the sat port and its register are absent. Saturation clamping of feet and inches behaves identically.

## Test plan
- Nominal: IN_W = 10, in_total = 70 → out_valid exactly 10 edges after accept; feet = 5, inches = 10, sat = 0.
- Boundaries:
  - in_total = 0 → 0 ft 0 in.
  - in_total = 107 → 8 ft 11 in, sat = 0.
  - in_total = 12 → 1 ft 0 in.
- Saturation:
  - in_total = 108 → feet = 8, inches = 11, sat = 1.
  - in_total = 1023 → 8 ft 11 in, sat = 1.
- Back-pressure: in_total = 70, out_ready held low for 20 cycles → outputs frozen at 5/10 and in_ready = 0 throughout. Release → handoff, then in_ready = 1 on the next cycle.
- Ignored input: in_valid pulsed with 99 during DIV of 70 → result is 5/10. The value 99 is never converted.
- Reset mid-DIV: assert rst_n = 0 at DIV cycle 4 → out_valid = 0 and all outputs 0 immediately. A new conversion of 36 afterwards → 3 ft 0 in.
